// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared op encodings, FSM states and iteration count for mul_div_unit
package mul_div_unit_pkg;
  localparam int ITER = 32;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
endpackage

// File: rtl/mul_div_unit_divu_step.sv
// mul_div_unit_divu_step: one combinational restoring-division iteration
// i_rem: partial remainder, i_q: dividend/quotient shift register, i_d: divisor
// o_rem/o_q: remainder and shift register after the step
module mul_div_unit_divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH:0] w_shift, w_diff;
  assign w_shift = {i_rem, i_q[WIDTH-1]};
  // extra top bit is the borrow: set means the trial subtract must be undone
  assign w_diff = w_shift - {1'b0, i_d};
  assign o_rem = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_q = {i_q[WIDTH-2:0], ~w_diff[WIDTH]};
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MULT/MULTU/DIV/DIVU unit holding the HI/LO registers
// clk/rstd: clock, async active-low reset; start/op/a/b: operation request (IDLE only)
// we_hi/we_lo/w_data: mthi/mtlo writes (IDLE only); busy/done: status; hi/lo: results
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic             clk,
  input  logic             rstd,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] w_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_e r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem, r_q, r_d, r_a, r_hi, r_lo;
  logic r_div, r_neg_q, r_neg_r, r_dz, r_done;
  logic w_go, w_last, w_sgn, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_drem, w_dq, w_quo, w_remf;
  logic [WIDTH:0] w_sum;
  logic [2*WIDTH-1:0] w_prod;
  op_e w_op;
  assign w_op = op_e'(op);
  assign w_go = r_state == IDLE && start;
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign w_sgn = w_op == OP_MULT || w_op == OP_DIV;
  assign w_a_neg = w_sgn & a[WIDTH-1];
  assign w_b_neg = w_sgn & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;
  // multiply: r_rem is the product upper half, r_q shifts out multiplier bits and in product bits
  assign w_sum = {1'b0, r_rem} + (r_q[0] ? {1'b0, r_d} : '0);
  assign w_prod = r_neg_q ? -{r_rem, r_q} : {r_rem, r_q};
  assign w_quo = r_neg_q ? -r_q : r_q;
  assign w_remf = r_neg_r ? -r_rem : r_rem;
  mul_div_unit_divu_step #(.WIDTH(WIDTH)) u_step (
    .i_rem(r_rem),
    .i_q  (r_q),
    .i_d  (r_d),
    .o_rem(w_drem),
    .o_q  (w_dq)
  );
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_last ? FIX : RUN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstd)
    if (!rstd) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rstd)
    if (!rstd) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_q <= '0;
      r_d <= '0;
      r_a <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_div <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= r_state == FIX;
      if (w_go) begin
        r_cnt <= '0;
        r_rem <= '0;
        r_q <= op[1] ? w_a_mag : w_b_mag;
        r_d <= op[1] ? w_b_mag : w_a_mag;
        r_a <= a;
        r_div <= op[1];
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_dz <= op[1] & ~|b;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= r_div ? w_drem : w_sum[WIDTH:1];
        r_q <= r_div ? w_dq : {w_sum[0], r_q[WIDTH-1:1]};
      end else if (r_state == FIX) begin
        r_hi <= r_dz ? r_a : r_div ? w_remf : w_prod[2*WIDTH-1:WIDTH];
        r_lo <= r_dz ? '1 : r_div ? w_quo : w_prod[WIDTH-1:0];
      end else begin
        if (we_hi) r_hi <= w_data;
        if (we_lo) r_lo <= w_data;
      end
    end
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign hi = r_hi;
  assign lo = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rstd = 1'b0;
  logic start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0, w_data = '0;
  logic we_hi = 1'b0, we_lo = 1'b0;
  logic busy, done;
  logic [31:0] hi, lo;
  int n_chk = 0;
  int n_err = 0;
  mul_div_unit dut (
    .clk   (clk),
    .rstd  (rstd),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .we_hi (we_hi),
    .we_lo (we_lo),
    .w_data(w_data),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check({tag, " cycles"}, 32'(n), 32'd33);
    check({tag, " done"}, {31'b0, done}, 32'd1);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    @(negedge clk);
    check({tag, " done_fall"}, {31'b0, done}, 32'd0);
  endtask
  initial begin
    int n;
    #3;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    @(negedge clk);
    rstd = 1'b1;
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("divu_z", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_op("div_z", 2'b10, 32'hFFFFFFF6, 32'd0, 32'hFFFFFFF6, 32'hFFFFFFFF);
    @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    a = 32'd3;
    b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    op = 2'b11;
    a = 32'd9;
    b = 32'd3;
    we_hi = 1'b1;
    w_data = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    we_hi = 1'b0;
    check("busy hi hold", hi, 32'hFFFFFFF6);
    check("busy lo hold", lo, 32'hFFFFFFFF);
    wait_done(n);
    check("busy cycles", 32'(n), 32'd28);
    check("busy done", {31'b0, done}, 32'd1);
    check("busy hi", hi, 32'd0);
    check("busy lo", lo, 32'd12);
    @(negedge clk);
    we_lo = 1'b1;
    w_data = 32'h1234;
    @(negedge clk);
    we_lo = 1'b0;
    check("mtlo lo", lo, 32'h1234);
    check("mtlo hi", hi, 32'd0);
    we_hi = 1'b1;
    we_lo = 1'b1;
    w_data = 32'hA5A5;
    @(negedge clk);
    we_hi = 1'b0;
    we_lo = 1'b0;
    check("both hi", hi, 32'hA5A5);
    check("both lo", lo, 32'hA5A5);
    start = 1'b1;
    op = 2'b01;
    a = 32'd2;
    b = 32'd2;
    we_hi = 1'b1;
    we_lo = 1'b1;
    w_data = 32'hBEEF;
    @(negedge clk);
    start = 1'b0;
    we_hi = 1'b0;
    we_lo = 1'b0;
    check("startwin busy", {31'b0, busy}, 32'd1);
    check("startwin hi drop", hi, 32'hA5A5);
    wait_done(n);
    check("startwin hi", hi, 32'd0);
    check("startwin lo", lo, 32'd4);
    @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    a = 32'd1;
    b = 32'd1;
    @(negedge clk);
    wait_done(n);
    check("held cycles", 32'(n), 32'd33);
    check("held lo", lo, 32'd1);
    a = 32'd5;
    b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    check("held reaccept", {31'b0, busy}, 32'd1);
    wait_done(n);
    check("held2 cycles", 32'(n), 32'd33);
    check("held2 lo", lo, 32'd30);
    @(negedge clk);
    start = 1'b1;
    op = 2'b11;
    a = 32'd100;
    b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rstd = 1'b0;
    #1;
    check("rstmid busy", {31'b0, busy}, 32'd0);
    check("rstmid hi", hi, 32'd0);
    check("rstmid lo", lo, 32'd0);
    check("rstmid done", {31'b0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rstmid done2", {31'b0, done}, 32'd0);
    rstd = 1'b1;
    run_op("after_rst", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
